// File: rtl/reg_dump_serializer.sv
// reg_dump_serializer
// Captures a snapshot of the flattened register bus when a start request
// arrives. It then streams the snapshot out one byte at a time over a
// valid/ready byte interface. Register 0 goes first, most significant byte first.
// REG_WIDTH must be a multiple of 8.
module reg_dump_serializer #(
  parameter int NUM_REGS  = 32,
  parameter int REG_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          i_reset_n,
  input  logic                          i_start,
  input  logic                          i_abort,
  input  logic [NUM_REGS*REG_WIDTH-1:0] i_registers,
  input  logic                          i_tx_ready,
  output logic [7:0]                    o_tx_data,
  output logic                          o_tx_valid,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int BUS_W = NUM_REGS * REG_WIDTH;
  localparam int TOTAL = BUS_W / 8;
  localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(TOTAL - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            state_reg, state_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  // Snapshot lanes: lane TOTAL-1 always holds the byte currently on offer.
  logic [TOTAL-1:0][7:0] snap_reg, snap_next;

  logic load_snap;
  logic xfer;

  assign load_snap = (state_reg == ST_IDLE) && i_start;
  assign xfer      = (state_reg == ST_SEND) && i_tx_ready;

  // Per-lane next value: load from the bus on start, shift toward the top on each transfer.
  // Byte b of the stream (bus bits [BUS_W-1-8b -: 8]) lands in lane TOTAL-1-b.
  generate
    for (genvar gi = 0; gi < TOTAL; gi++) begin : g_lane
      if (gi == 0) begin : g_bottom
        assign snap_next[gi] = load_snap ? i_registers[8*gi +: 8] :
                               xfer      ? 8'h00                  :
                                           snap_reg[gi];
      end else begin : g_upper
        assign snap_next[gi] = load_snap ? i_registers[8*gi +: 8] :
                               xfer      ? snap_reg[gi-1]         :
                                           snap_reg[gi];
      end
    end
  endgenerate

  // Snapshot storage; its contents are meaningless outside a dump, so it has no reset.
  always_ff @(posedge clk) begin
    snap_reg <= snap_next;
  end

  // Next-state and byte-counter logic; abort beats last-byte completion.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          state_next = ST_SEND;
          count_next = '0;
        end
      end
      ST_SEND: begin
        if (i_abort) begin
          state_next = ST_IDLE;
        end else if (i_tx_ready) begin
          if (count_reg == LAST_BYTE) begin
            state_next = ST_DONE;
          end else begin
            count_next = count_reg + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and counter registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Outputs decode straight from state, so reset clears them without waiting for a clock.
  always_comb begin
    o_tx_valid = (state_reg == ST_SEND);
    o_busy     = (state_reg != ST_IDLE);
    o_done     = (state_reg == ST_DONE);
    o_tx_data  = o_tx_valid ? snap_reg[TOTAL-1] : 8'h00;
  end

endmodule

// File: tb/tb_reg_dump_serializer.sv
// Directed testbench for reg_dump_serializer at default parameters.
// The expected byte stream is 0x00..0x7F, which comes from the register pattern set below.
module tb_reg_dump_serializer;

  localparam int NUM_REGS  = 32;
  localparam int REG_WIDTH = 32;
  localparam int BUS_W     = NUM_REGS * REG_WIDTH;
  localparam int TOTAL     = BUS_W / 8;

  logic             clk = 1'b0;
  logic             i_reset_n;
  logic             i_start;
  logic             i_abort;
  logic [BUS_W-1:0] i_registers;
  logic             i_tx_ready;
  logic [7:0]       o_tx_data;
  logic             o_tx_valid;
  logic             o_busy;
  logic             o_done;

  int n_checks = 0;
  int n_errors = 0;

  reg_dump_serializer #(
    .NUM_REGS  (NUM_REGS),
    .REG_WIDTH (REG_WIDTH)
  ) dut (
    .clk         (clk),
    .i_reset_n   (i_reset_n),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_registers (i_registers),
    .i_tx_ready  (i_tx_ready),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Register k = {4k, 4k+1, 4k+2, 4k+3}, so stream byte b carries the value b.
  task automatic load_pattern();
    for (int b = 0; b < TOTAL; b++) begin
      i_registers[BUS_W-1-8*b -: 8] = 8'(b);
    end
  endtask

  // Called at a negedge. This task raises start, and optionally abort, for one edge.
  // It returns at the following negedge.
  task automatic pulse_start(input bit with_abort);
    i_start = 1'b1;
    i_abort = with_abort;
    @(negedge clk);
    i_start = 1'b0;
    i_abort = 1'b0;
  endtask

  // Consume stop_at bytes and check each offered byte against its index.
  // mode 0: ready always high.
  // mode 1: ready held low 10 cycles on byte 5, then toggles.
  // mode 2: start at byte 20, abort on the edge where byte 50 transfers.
  task automatic consume(input int mode, input int stop_at);
    int exp_b = 0;
    int cyc   = 0;
    int stall = 0;
    bit tog   = 1'b0;
    while (exp_b < stop_at && cyc < 1000) begin
      i_start = 1'b0;
      i_abort = 1'b0;
      check("valid", o_tx_valid, 1);
      check("busy", o_busy, 1);
      check("data", o_tx_data, exp_b);
      if (mode == 1 && exp_b == 5 && stall < 10) begin
        i_tx_ready = 1'b0;
        stall++;
      end else if (mode == 1 && exp_b > 5) begin
        i_tx_ready = tog;
        tog = ~tog;
      end else begin
        i_tx_ready = 1'b1;
      end
      if (mode == 2 && exp_b == 20) i_start = 1'b1;
      if (mode == 2 && exp_b == 50) i_abort = 1'b1;
      if (i_tx_ready) exp_b++;
      @(negedge clk);
      cyc++;
    end
    i_start    = 1'b0;
    i_abort    = 1'b0;
    i_tx_ready = 1'b1;
    if (exp_b != stop_at) check("byte_budget", exp_b, stop_at);
  endtask

  // Called at the negedge after the last byte was accepted.
  // A start raised during DONE must be ignored.
  task automatic finish_dump(input string name);
    check("done_pulse", o_done, 1);
    check("done_busy", o_busy, 1);
    check("done_valid", o_tx_valid, 0);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("after_done", o_done, 0);
    check("after_busy", o_busy, 0);
    check("after_valid", o_tx_valid, 0);
    $display("dump %s: %0d bytes, done pulse seen=%0d", name, TOTAL, (n_errors == 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset_n  = 1'b0;
    i_start    = 1'b1;
    i_abort    = 1'b0;
    i_tx_ready = 1'b1;
    load_pattern();

    // Reset holds everything idle even with start high.
    repeat (3) begin
      @(negedge clk);
      check("rst_valid", o_tx_valid, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_data", o_tx_data, 0);
    end
    i_start   = 1'b0;
    i_reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_valid", o_tx_valid, 0);
      check("post_rst_busy", o_busy, 0);
    end
    $display("reset: outputs idle");

    // Full dump with ready always high.
    pulse_start(1'b0);
    consume(0, TOTAL);
    finish_dump("full");

    // Backpressure. Start and abort are raised together in IDLE, and start wins.
    pulse_start(1'b1);
    consume(1, TOTAL);
    finish_dump("backpressure");

    // Snapshot isolation: the bus changes right after the start edge.
    pulse_start(1'b0);
    i_registers = '1;
    consume(0, TOTAL);
    load_pattern();
    finish_dump("snapshot");

    // A start during the dump is ignored. Abort coincides with the transfer of byte 50.
    pulse_start(1'b0);
    consume(2, 51);
    check("abort_valid", o_tx_valid, 0);
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    @(negedge clk);
    check("abort_done2", o_done, 0);
    check("abort_busy2", o_busy, 0);
    $display("dump abort: stopped after byte 50");
    pulse_start(1'b0);
    consume(0, TOTAL);
    finish_dump("restart_after_abort");

    // Asynchronous reset between edges at byte 64.
    pulse_start(1'b0);
    consume(0, 64);
    #2 i_reset_n = 1'b0;
    #1;
    check("arst_valid", o_tx_valid, 0);
    check("arst_busy", o_busy, 0);
    check("arst_data", o_tx_data, 0);
    check("arst_done", o_done, 0);
    @(negedge clk);
    i_reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("arst_idle_valid", o_tx_valid, 0);
    end
    $display("dump reset: cleared at byte 64");
    pulse_start(1'b0);
    consume(0, TOTAL);
    finish_dump("restart_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
